// File: rtl/microbot_pkg.sv
// Shared definitions for the microbot controller.
// Contents: controller state encoding, seven-segment patterns per state,
// default phase lengths, and the motor-direction decode used by the top.
package microbot_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FORWARD,
      S_TURN_LEFT,
      S_TURN_RIGHT,
      S_REVERSE,
      S_GRAB,
      S_HALT
   } state_t;

   // Segment patterns, bit0 = a ... bit6 = g, active high
   localparam logic [6:0] SEG_IDLE       = 7'h3F;  // "0"
   localparam logic [6:0] SEG_FORWARD    = 7'h06;  // "1"
   localparam logic [6:0] SEG_TURN_LEFT  = 7'h5B;  // "2"
   localparam logic [6:0] SEG_TURN_RIGHT = 7'h4F;  // "3"
   localparam logic [6:0] SEG_REVERSE    = 7'h66;  // "4"
   localparam logic [6:0] SEG_GRAB       = 7'h6D;  // "5"
   localparam logic [6:0] SEG_HALT       = 7'h79;  // "E"

   localparam int unsigned DEFAULT_TURN_CYCLES    = 16;
   localparam int unsigned DEFAULT_REVERSE_CYCLES = 8;
   localparam int unsigned DEFAULT_GRAB_CYCLES    = 4;

   localparam int unsigned TIMER_W = 16;

   // Returns {right_rev, right_fwd, left_rev, left_fwd} before PWM gating
   function automatic logic [3:0] motor_dir(state_t s);
      logic [3:0] m;
      m = '0;
      case (s)
         S_FORWARD:    m = 4'b0101;
         S_TURN_LEFT:  m = 4'b0110;
         S_TURN_RIGHT: m = 4'b1001;
         S_REVERSE:    m = 4'b1010;
         default:      m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/seg7_state_decoder.sv
// Seven-segment decoder: shows the controller state as a digit.
// Ports:
//   state    - current controller state
//   segments - a..g pattern (bit0 = a), active high
module seg7_state_decoder
   import microbot_pkg::*;
(
   input  state_t     state,
   output logic [6:0] segments
);

   always_comb begin
      segments = SEG_IDLE;
      case (state)
         S_IDLE:       segments = SEG_IDLE;
         S_FORWARD:    segments = SEG_FORWARD;
         S_TURN_LEFT:  segments = SEG_TURN_LEFT;
         S_TURN_RIGHT: segments = SEG_TURN_RIGHT;
         S_REVERSE:    segments = SEG_REVERSE;
         S_GRAB:       segments = SEG_GRAB;
         S_HALT:       segments = SEG_HALT;
         default:      segments = SEG_HALT;
      endcase
   end

endmodule

// File: rtl/tt_um_controlador_microbots.sv
// Microbot motion controller: Moore FSM driving two PWM-gated motors,
// a state digit on a seven-segment display and a 4-bit grab counter.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   ena        - design-selected flag (unused)
//   ui_in      - [0] start [1] stop [2] obstacle_left [3] obstacle_right
//                [4] target [7:5] speed
//   uo_out     - [6:0] segments a..g, [7] moving
//   uio_in     - unused
//   uio_out    - [0] left_fwd [1] left_rev [2] right_fwd [3] right_rev
//                [7:4] grab_count
//   uio_oe     - constant all-ones
module tt_um_controlador_microbots
   import microbot_pkg::*;
#(
   parameter int unsigned TURN_CYCLES    = DEFAULT_TURN_CYCLES,
   parameter int unsigned REVERSE_CYCLES = DEFAULT_REVERSE_CYCLES,
   parameter int unsigned GRAB_CYCLES    = DEFAULT_GRAB_CYCLES
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [TIMER_W-1:0] TURN_LAST    = TIMER_W'(TURN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] REVERSE_LAST = TIMER_W'(REVERSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GRAB_LAST    = TIMER_W'(GRAB_CYCLES - 1);

   logic       start, stop, obstacle_left, obstacle_right, target;
   logic [2:0] speed;

   assign start          = ui_in[0];
   assign stop           = ui_in[1];
   assign obstacle_left  = ui_in[2];
   assign obstacle_right = ui_in[3];
   assign target         = ui_in[4];
   assign speed          = ui_in[7:5];

   state_t               state, state_next;
   logic [TIMER_W-1:0]   timer, timer_next;
   logic                 grab_done;
   logic [2:0]           pwm_cnt;
   logic                 pwm_on;
   logic [3:0]           grab_count;
   logic [6:0]           segments;
   logic                 moving;
   logic [3:0]           motors;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         timer      <= '0;
         pwm_cnt    <= '0;
         pwm_on     <= 1'b0;
         grab_count <= '0;
      end else begin
         state   <= state_next;
         timer   <= timer_next;
         pwm_cnt <= pwm_cnt + 3'd1;
         pwm_on  <= (pwm_cnt <= speed);
         if (grab_done)
            grab_count <= grab_count + 4'd1;
      end
   end

   // Timer counts up from 0 on entry; leaving when it reaches N-1 gives N cycles
   always_comb begin
      state_next = state;
      timer_next = '0;
      grab_done  = 1'b0;
      if (stop) begin
         state_next = S_HALT;
      end else begin
         case (state)
            S_IDLE:
               if (start) state_next = S_FORWARD;
            S_FORWARD: begin
               if (target)                             state_next = S_GRAB;
               else if (obstacle_left && obstacle_right) state_next = S_REVERSE;
               else if (obstacle_left)                 state_next = S_TURN_RIGHT;
               else if (obstacle_right)                state_next = S_TURN_LEFT;
            end
            S_TURN_LEFT, S_TURN_RIGHT: begin
               if (timer == TURN_LAST) state_next = S_FORWARD;
               else                    timer_next = timer + 1'b1;
            end
            S_REVERSE: begin
               if (timer == REVERSE_LAST) state_next = S_TURN_LEFT;
               else                       timer_next = timer + 1'b1;
            end
            S_GRAB: begin
               if (timer == GRAB_LAST) begin
                  state_next = S_IDLE;
                  grab_done  = 1'b1;
               end else begin
                  timer_next = timer + 1'b1;
               end
            end
            S_HALT:
               if (!start) state_next = S_IDLE;
            default:
               state_next = S_HALT;
         endcase
      end
   end

   seg7_state_decoder u_seg (
      .state    (state),
      .segments (segments)
   );

   assign moving = (state == S_FORWARD) || (state == S_TURN_LEFT) ||
                   (state == S_TURN_RIGHT) || (state == S_REVERSE);
   assign motors = motor_dir(state) & {4{pwm_on}};

   assign uo_out  = {moving, segments};
   assign uio_out = {grab_count, motors};
   assign uio_oe  = '1;

   logic unused;
   assign unused = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_tt_um_controlador_microbots.sv
module tb_tt_um_controlador_microbots;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   always #5 clk = ~clk;

   tt_um_controlador_microbots #(
      .TURN_CYCLES    (16),
      .REVERSE_CYCLES (8),
      .GRAB_CYCLES    (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // Reference model: behaviour as a mode plus "cycles remaining" countdown
   localparam int M_IDLE = 0, M_FWD = 1, M_TL = 2, M_TR = 3, M_REV = 4,
                  M_GRAB = 5, M_HALT = 6;
   localparam int N_TURN = 16, N_REV = 8, N_GRAB = 4;

   int m_mode, m_rem, m_grabs, m_phase;
   bit m_on;

   typedef struct {
      string      tag;
      logic [7:0] uo;
      logic [7:0] uio;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [6:0] seg_of(int m);
      case (m)
         M_IDLE: return 7'h3F;
         M_FWD:  return 7'h06;
         M_TL:   return 7'h5B;
         M_TR:   return 7'h4F;
         M_REV:  return 7'h66;
         M_GRAB: return 7'h6D;
         default: return 7'h79;
      endcase
   endfunction

   // {right_rev, right_fwd, left_rev, left_fwd}
   function automatic logic [3:0] dir_of(int m);
      case (m)
         M_FWD: return 4'b0101;
         M_TL:  return 4'b0110;
         M_TR:  return 4'b1001;
         M_REV: return 4'b1010;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic enter(input int m, input int n);
      m_mode = m;
      m_rem  = n;
   endtask

   task automatic model_edge(input bit r, st, sp, ol, orr, tg, input int spd);
      if (!r) begin
         m_mode = M_IDLE; m_rem = 0; m_grabs = 0; m_phase = 0; m_on = 0;
         return;
      end
      m_on    = (m_phase <= spd);
      m_phase = (m_phase + 1) % 8;
      if (sp) begin
         m_mode = M_HALT; m_rem = 0;
      end else begin
         case (m_mode)
            M_HALT: if (!st) m_mode = M_IDLE;
            M_IDLE: if (st) m_mode = M_FWD;
            M_FWD: begin
               if (tg)              enter(M_GRAB, N_GRAB);
               else if (ol && orr)  enter(M_REV, N_REV);
               else if (ol)         enter(M_TR, N_TURN);
               else if (orr)        enter(M_TL, N_TURN);
            end
            default: begin
               m_rem--;
               if (m_rem == 0) begin
                  case (m_mode)
                     M_TL, M_TR: m_mode = M_FWD;
                     M_REV:      enter(M_TL, N_TURN);
                     M_GRAB: begin
                        m_mode  = M_IDLE;
                        m_grabs = (m_grabs + 1) % 16;
                     end
                     default: m_mode = M_HALT;
                  endcase
               end
            end
         endcase
      end
   endtask

   task automatic drive(input bit r, st, sp, ol, orr, tg, input int spd, input string tag);
      exp_t e;
      logic [3:0] g;
      @(negedge clk);
      rst_n  = r;
      ui_in  = {3'(spd), tg, orr, ol, sp, st};
      uio_in = 8'($urandom);
      ena    = 1'($urandom);
      model_edge(r, st, sp, ol, orr, tg, spd);
      g = 4'(m_grabs);
      e.tag = tag;
      e.uo  = {(m_mode == M_FWD || m_mode == M_TL || m_mode == M_TR || m_mode == M_REV),
               seg_of(m_mode)};
      e.uio = {g, dir_of(m_mode) & {4{m_on}}};
      sb.push_back(e);
   endtask

   task automatic quiet(input int n, input int spd, input string tag);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, spd, tag);
   endtask

   // Monitor: outputs are valid every cycle, so each edge retires one entry
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (uo_out !== e.uo) begin
               errors++;
               $display("FAIL %s uo_out got %h expected %h", e.tag, uo_out, e.uo);
            end
            checks++;
            if (uio_out !== e.uio) begin
               errors++;
               $display("FAIL %s uio_out got %h expected %h", e.tag, uio_out, e.uio);
            end
            checks++;
            if (uio_oe !== 8'hFF) begin
               errors++;
               $display("FAIL %s uio_oe got %h expected ff", e.tag, uio_oe);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; ui_in = '0; uio_in = '0; ena = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 7, "reset");
      drive(0, 0, 0, 0, 0, 0, 7, "reset");

      // Start to FORWARD at full speed
      drive(1, 1, 0, 0, 0, 0, 7, "start");
      quiet(3, 7, "forward");

      // Left obstacle -> TURN_RIGHT then FORWARD
      drive(1, 0, 0, 1, 0, 0, 7, "obst_left");
      quiet(19, 7, "turn_right");

      // Both obstacles -> REVERSE -> TURN_LEFT -> FORWARD
      drive(1, 0, 0, 1, 1, 0, 7, "obst_both");
      quiet(28, 7, "reverse_turn_left");

      // Sixteen grabs: count wraps back to 0
      for (int k = 0; k < 16; k++) begin
         if (k > 0) drive(1, 1, 0, 0, 0, 0, 7, "grab_start");
         drive(1, 0, 0, 0, 0, 1, 7, "grab_target");
         quiet(6, 7, "grab");
      end

      // Stop during a turn, then release
      drive(1, 1, 0, 0, 0, 0, 7, "halt_start");
      drive(1, 0, 0, 1, 0, 0, 7, "halt_obst");
      quiet(5, 7, "halt_turn");
      drive(1, 0, 1, 0, 0, 0, 7, "halt_stop");
      drive(1, 1, 1, 0, 0, 0, 7, "halt_stop");
      drive(1, 1, 0, 0, 0, 0, 7, "halt_hold_start");
      quiet(3, 7, "halt_release");

      // Stop during GRAB leaves grab_count untouched
      drive(1, 1, 0, 0, 0, 0, 7, "gstop_start");
      drive(1, 0, 0, 0, 0, 1, 7, "gstop_target");
      quiet(2, 7, "gstop_grab");
      drive(1, 0, 1, 0, 0, 0, 7, "gstop_stop");
      quiet(3, 7, "gstop_release");

      // Minimum speed: 1 of 8 cycles driven
      drive(1, 1, 0, 0, 0, 0, 0, "slow_start");
      quiet(24, 0, "slow_forward");

      // Reset in the middle of GRAB
      drive(1, 0, 0, 0, 0, 1, 3, "rst_target");
      quiet(2, 3, "rst_grab");
      drive(0, 0, 0, 0, 0, 0, 3, "rst_mid");
      quiet(3, 3, "rst_after");

      // Randomized operation
      for (int i = 0; i < 3000; i++) begin
         bit r, st, sp, ol, orr, tg;
         r   = ($urandom_range(0, 299) != 0);
         st  = ($urandom_range(0, 3) == 0);
         sp  = ($urandom_range(0, 24) == 0);
         ol  = ($urandom_range(0, 7) == 0);
         orr = ($urandom_range(0, 7) == 0);
         tg  = ($urandom_range(0, 11) == 0);
         drive(r, st, sp, ol, orr, tg, $urandom_range(0, 7), "random");
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_um_controlador_microbots.md
TT_UM_CONTROLADOR_MICROBOTS -- requirements
Module: tt_um_controlador_microbots

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 16, which sets the cycles spent in TURN_LEFT/TURN_RIGHT.
REQ-002 SHALL have parameter REVERSE_CYCLES, default 8, which sets the cycles spent in REVERSE.
REQ-003 SHALL have parameter GRAB_CYCLES, default 4, which sets the cycles spent in GRAB.
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port ena  in  1  design-selected flag; ignored.
REQ-007 SHALL have port ui_in  in  8  as follows: [0] start, [1] stop, [2] obstacle_left, [3] obstacle_right, [4] target, [7:5] speed.
REQ-008 SHALL have port uo_out  out  8  as follows: [6:0] seven-segment a..g (bit0 = a, active high), [7] moving.
REQ-009 SHALL have port uio_in  in  8  unused; ignored.
REQ-010 SHALL have port uio_out  out  8  as follows: [0] left_fwd, [1] left_rev, [2] right_fwd, [3] right_rev, [7:4] grab_count.
REQ-011 SHALL have port uio_oe  out  8  held at constant 8'hFF.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, FORWARD, TURN_LEFT, TURN_RIGHT, REVERSE, GRAB, HALT; inputs are sampled at the clock edge, and outputs decode from registered state (one-cycle latency from input to output).
REQ-013 SHALL make stop=1 force HALT from any state on the next edge, with highest priority; the phase timer clears.
REQ-014 SHALL make HALT go to IDLE only when stop=0 and start=0 are seen on the same edge.
REQ-015 SHALL make IDLE go to FORWARD when start=1 (and stop=0).
REQ-016 SHALL evaluate FORWARD in this priority order: target -> GRAB; both obstacles -> REVERSE; obstacle_left -> TURN_RIGHT; obstacle_right -> TURN_LEFT; otherwise remain in FORWARD.
REQ-017 SHALL clear the phase timer on entry to TURN_LEFT, TURN_RIGHT, REVERSE or GRAB.
REQ-018 SHALL keep the FSM in each timed state exactly its parameter count of cycles, then exit: TURN_* -> FORWARD, REVERSE -> TURN_LEFT, GRAB -> IDLE.
REQ-019 SHALL ignore obstacle and target inputs during timed states.
REQ-020 SHALL increment grab_count (4 bit) on GRAB exit and wrap 15 -> 0; a stop during GRAB does not increment it.
REQ-021 SHALL display segments per state: IDLE 0x3F ("0"), FORWARD 0x06 ("1"), TURN_LEFT 0x5B ("2"), TURN_RIGHT 0x4F ("3"), REVERSE 0x66 ("4"), GRAB 0x6D ("5"), HALT 0x79 ("E").
REQ-022 SHALL drive moving=1 in FORWARD, TURN_LEFT, TURN_RIGHT and REVERSE, and 0 otherwise.
REQ-023 SHALL set motor direction bits as follows: FORWARD left_fwd, right_fwd; TURN_LEFT left_rev, right_fwd; TURN_RIGHT left_fwd, right_rev; REVERSE left_rev, right_rev; all other states 0.
REQ-024 SHALL use a free-running 3-bit PWM counter; pwm_on = (pwm_cnt <= speed); motor bits are ANDed with registered pwm_on.
REQ-025 SHALL make speed=7 give motors always on and speed=0 give 1 of 8 cycles on.
REQ-026 SHALL NOT gate moving, segments or grab_count by PWM.

Reset
REQ-027 SHALL, while rst_n=0 at an edge, set state to IDLE, phase timer 0, pwm_cnt 0, and grab_count 0.
REQ-028 SHALL, one edge after reset, output uo_out=0x3F, uio_out[3:0]=0, uio_out[7:4]=0, and uio_oe=0xFF.
REQ-029 SHALL abort any state on a reset asserted mid-operation, with no grab_count increment.

Structure
REQ-030 SHALL place the state encoding enum, segment constants and default timing constants in shared package microbot_pkg.
REQ-031 SHALL implement the seven-segment decoder as one natural sub-module, seg7_state_decoder (state in, 7-bit segments out).

Verification
REQ-032 SHALL check: reset, then start=1 for one cycle -> uo_out=0x86 (FORWARD, moving) one cycle later, and with speed=7, uio_out[3:0]=0x5.
REQ-033 SHALL check: in FORWARD, set obstacle_left=1 -> TURN_RIGHT (0x4F) for exactly 16 cycles, and uio_out[3:0]=0x9 with speed=7, then FORWARD.
REQ-034 SHALL check: in FORWARD, set both obstacles -> REVERSE for 8 cycles (uio_out[3:0]=0xA), then TURN_LEFT for 16 cycles (0x6), then FORWARD.
REQ-035 SHALL check: in FORWARD, set target=1 -> GRAB (0x6D) for 4 cycles, then IDLE, with grab_count=1; sixteen grabs -> grab_count=0.
REQ-036 SHALL check: stop=1 during a TURN -> HALT (0x79, motors 0); release stop/start -> IDLE; stop during GRAB -> grab_count unchanged.
REQ-037 SHALL check: speed=0 in FORWARD -> motor bits high exactly 1 of every 8 cycles, with moving held at 1.
